hazard_sequencer: RTL and testbench

- Pipeline control unit for the 5-stage MIPS core.
- Generates write-enable, flush and bubble controls for the PC, IF/ID and ID/EX registers.
- Sequences three events in a fixed priority order: data-memory wait (whole pipe frozen), taken branch/jump (IF/ID flushed for a configurable penalty), and load-use hazard (1-cycle bubble).
- Also keeps saturating stall/flush statistics and a sticky memory-timeout flag.

---
 rtl/hazard_sequencer_if.sv | 39 +++
 rtl/hazard_sequencer.sv | 138 +++++++++++++
 tb/tb_hazard_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_if.sv
// Hazard control bundle between the 5-stage pipeline datapath and its hazard sequencer.
interface hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_uses_rt_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rt_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic             dmem_req_i;
    logic             dmem_ready_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_hold_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             timeout_o;

    // Pipeline side: supplies hazard sources, consumes register controls.
    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
               branch_taken_i, jump_i, dmem_req_i, dmem_ready_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               pipe_hold_o, state_o, stall_cnt_o, flush_cnt_o, timeout_o
    );

    // Sequencer side.
    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
               branch_taken_i, jump_i, dmem_req_i, dmem_ready_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               pipe_hold_o, state_o, stall_cnt_o, flush_cnt_o, timeout_o
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer for the 5-stage MIPS core.
//
// state    | meaning
// RUN      | normal issue; branches start a flush, load-use inserts a bubble
// FLUSH    | IF/ID cleared for the remaining branch penalty cycles
// MEM_WAIT | data memory busy, whole pipe frozen; returns to RUN or FLUSH
module hazard_sequencer #(
    parameter int BR_PENALTY  = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hazard_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [7:0]       TO_MAX  = 8'(MEM_TIMEOUT);
    localparam logic [7:0]       TO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [2:0]       PEN_REM = 3'(BR_PENALTY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d, eff_state;
    logic [2:0]       flush_left_q, flush_left_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             ret_flush_q, ret_flush_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_hold, lu, br;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;

    // Hazard decode, Mealy control outputs and next-state selection.
    always_comb begin
        mem_hold = bus.dmem_req_i & ~bus.dmem_ready_i;
        lu = bus.ex_memread_i & (bus.ex_rt_i != 5'd0) &
             ((bus.ex_rt_i == bus.id_rs_i) |
              (bus.id_uses_rt_i & (bus.ex_rt_i == bus.id_rt_i)));
        br = bus.branch_taken_i | bus.jump_i;

        // On release from MEM_WAIT the cycle behaves as the state we return to.
        eff_state = state_q;
        if (state_q == ST_MEM_WAIT)
            eff_state = (ret_flush_q && flush_left_q != 3'd0) ? ST_FLUSH : ST_RUN;

        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        pipe_hold    = 1'b0;
        state_d      = state_q;
        flush_left_d = flush_left_q;
        wait_cnt_d   = wait_cnt_q;
        ret_flush_d  = ret_flush_q;
        timeout_d    = timeout_q;

        if (mem_hold) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            state_d    = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                ret_flush_d = (state_q == ST_FLUSH);
                wait_cnt_d  = 8'd0;
            end else begin
                if (wait_cnt_q < TO_MAX)
                    wait_cnt_d = wait_cnt_q + 8'd1;
                if (wait_cnt_q >= TO_LAST)
                    timeout_d = 1'b1;
            end
        end else begin
            wait_cnt_d  = 8'd0;
            ret_flush_d = 1'b0;
            if (eff_state == ST_FLUSH) begin
                ifid_flush = 1'b1;
                if (flush_left_q != 3'd0)
                    flush_left_d = flush_left_q - 3'd1;
                state_d = (flush_left_q <= 3'd1) ? ST_RUN : ST_FLUSH;
            end else begin
                state_d = ST_RUN;
                if (br) begin
                    ifid_flush = 1'b1;
                    if (BR_PENALTY > 1) begin
                        flush_left_d = PEN_REM;
                        state_d      = ST_FLUSH;
                    end
                end else if (lu) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_write && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + 1'b1;
        flush_cnt_d = flush_cnt_q;
        if (ifid_flush && flush_cnt_q != CNT_MAX)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // State, sequencing counters and statistics registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            flush_left_q <= 3'd0;
            wait_cnt_q   <= 8'd0;
            ret_flush_q  <= 1'b0;
            timeout_q    <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            wait_cnt_q   <= wait_cnt_d;
            ret_flush_q  <= ret_flush_d;
            timeout_q    <= timeout_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bus.pc_write_o    = pc_write;
    assign bus.ifid_write_o  = ifid_write;
    assign bus.ifid_flush_o  = ifid_flush;
    assign bus.idex_bubble_o = idex_bubble;
    assign bus.pipe_hold_o   = pipe_hold;
    assign bus.state_o       = state_q;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;
    assign bus.timeout_o     = timeout_q;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer (BR_PENALTY=3, MEM_TIMEOUT=64).
module tb_hazard_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_sequencer_if #(.CNT_W(16)) hif ();

    hazard_sequencer #(
        .BR_PENALTY (3),
        .MEM_TIMEOUT(64),
        .CNT_W      (16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (hif)
    );

    // ctrl = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic       jmp;
        logic       req;
        logic       rdy;
        logic [4:0] ctrl;
        logic [1:0] st;
        int         stall;
        int         flc;
        logic       to;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl[NV];

    function automatic vec_t mk(int rs, int rt, bit ur, bit mr, int ert, bit br, bit jmp,
                                bit req, bit rdy, logic [4:0] ctrl, int st, int stall,
                                int flc, bit to);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = ur; v.memread = mr; v.ex_rt = 5'(ert);
        v.br = br; v.jmp = jmp; v.req = req; v.rdy = rdy;
        v.ctrl = ctrl; v.st = 2'(st); v.stall = stall; v.flc = flc; v.to = to;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        hif.id_rs_i        = v.rs;
        hif.id_rt_i        = v.rt;
        hif.id_uses_rt_i   = v.uses_rt;
        hif.ex_memread_i   = v.memread;
        hif.ex_rt_i        = v.ex_rt;
        hif.branch_taken_i = v.br;
        hif.jump_i         = v.jmp;
        hif.dmem_req_i     = v.req;
        hif.dmem_ready_i   = v.rdy;
    endtask

    function automatic int ctrl_now();
        return int'({hif.pc_write_o, hif.ifid_write_o, hif.ifid_flush_o,
                     hif.idex_bubble_o, hif.pipe_hold_o});
    endfunction

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0,0,0,0,0,0, 5'b11000, 0, 0, 0, 0);

        //            rs rt ur mr ert br j  rq rdy ctrl      st stall flc to
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 1,  0,  0);
        tbl[1]  = mk(8, 0, 0, 1, 8, 0, 0, 0, 0, 5'b00010, 0, 1,  0,  0);
        tbl[2]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11000, 0, 2,  0,  0);
        tbl[3]  = mk(3, 9, 1, 1, 9, 0, 0, 0, 0, 5'b00010, 0, 2,  0,  0);
        tbl[4]  = mk(3, 9, 0, 1, 9, 0, 0, 0, 0, 5'b11000, 0, 3,  0,  0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11100, 0, 3,  0,  0);
        tbl[6]  = mk(8, 0, 0, 1, 8, 1, 0, 0, 0, 5'b11100, 1, 3,  1,  0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 1, 3,  2,  0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 3,  3,  0);
        tbl[9]  = mk(8, 0, 0, 1, 8, 1, 0, 0, 0, 5'b11100, 0, 3,  3,  0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 1, 3,  4,  0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 1, 3,  5,  0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11100, 0, 3,  6,  0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 1, 3,  7,  0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 2, 4,  7,  0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 2, 5,  7,  0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 2, 6,  7,  0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11100, 2, 7,  7,  0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 1, 7,  8,  0);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 7,  9,  0);
        tbl[20] = mk(8, 0, 0, 1, 8, 1, 0, 1, 0, 5'b00001, 0, 7,  9,  0);
        tbl[21] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11100, 2, 8,  9,  0);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 1, 8,  10, 0);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 1, 8,  11, 0);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 0, 8,  12, 0);
        tbl[25] = mk(8, 0, 0, 1, 8, 0, 0, 0, 0, 5'b00010, 2, 9,  12, 0);
        tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 10, 12, 0);

        // Reset held 2 cycles while memory is busy.
        drive(idle);
        hif.dmem_req_i = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_state", int'(hif.state_o), 0);
        chk("rst_stall", int'(hif.stall_cnt_o), 0);
        chk("rst_flush", int'(hif.flush_cnt_o), 0);
        chk("rst_timeout", int'(hif.timeout_o), 0);
        chk("rst_ctrl_hold", ctrl_now(), 5'b00001);
        @(negedge clk);
        chk("rst_next_state", int'(hif.state_o), 2);
        hif.dmem_req_i = 1'b0;
        #1;
        chk("rst_release_ctrl", ctrl_now(), 5'b11000);

        // Table-driven cycle sequence.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_ctrl", i), ctrl_now(), int'(tbl[i].ctrl));
            chk($sformatf("v%0d_state", i), int'(hif.state_o), int'(tbl[i].st));
            chk($sformatf("v%0d_stall", i), int'(hif.stall_cnt_o), tbl[i].stall);
            chk($sformatf("v%0d_flushcnt", i), int'(hif.flush_cnt_o), tbl[i].flc);
            chk($sformatf("v%0d_timeout", i), int'(hif.timeout_o), int'(tbl[i].to));
        end

        // Memory timeout: 70 cycles of busy memory.
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hif.dmem_req_i = 1'b1;
        for (int k = 0; k < 70; k++) begin
            #1;
            chk($sformatf("to_c%0d_timeout", k), int'(hif.timeout_o), (k >= 65) ? 1 : 0);
            chk($sformatf("to_c%0d_state", k), int'(hif.state_o), (k == 0) ? 0 : 2);
            if (k == 0 || k == 64 || k == 69)
                chk($sformatf("to_c%0d_stall", k), int'(hif.stall_cnt_o), k);
            @(negedge clk);
        end
        hif.dmem_req_i = 1'b0;
        #1;
        chk("to_release_ctrl", ctrl_now(), 5'b11000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to_sticky%0d", k), int'(hif.timeout_o), 1);
            chk($sformatf("to_sticky%0d_state", k), int'(hif.state_o), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("to_cleared", int'(hif.timeout_o), 0);
        chk("to_cleared_stall", int'(hif.stall_cnt_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
